// File: rtl/decoder_seq_nx.sv
// decoder_seq_nx: registered SEL_W-to-NUM_OUT one-hot decoder.
// DIRECT mode decodes a code taken over a valid/ready handshake.
// SCAN mode steps the active line through all outputs with a dwell counter.
// Build option: define DECODER_ACTIVE_LOW_EN to make Do active-low
// (the active line is the single 0, and the off value is all ones).
module decoder_seq_nx #(
    parameter int SEL_W   = 3,
    parameter int NUM_OUT = 8,
    parameter int DWELL   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               En,
    input  logic               Mode,
    input  logic               Din_valid,
    input  logic [SEL_W-1:0]   Din,
    output logic               Din_ready,
    output logic [NUM_OUT-1:0] Do,
    output logic [SEL_W-1:0]   Code,
    output logic               Err,
    output logic               Wrap
);

    localparam int CNT_W = $clog2(DWELL) + 1;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] LAST_CODE  = SEL_W'(NUM_OUT - 1);
    localparam logic [SEL_W:0]   LIMIT      = (SEL_W + 1)'(NUM_OUT);

`ifdef DECODER_ACTIVE_LOW_EN
    localparam logic ACTIVE_LOW = 1'b1;
`else
    localparam logic ACTIVE_LOW = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [NUM_OUT-1:0] hot_r, hot_s;
    logic [SEL_W-1:0]   code_r, code_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               err_r, err_s;
    logic               wrap_r, wrap_s;
    logic               xfer_s;
    logic               in_range_s;

    function automatic logic [NUM_OUT-1:0] onehot(input logic [SEL_W-1:0] c);
        onehot = NUM_OUT'(1'b1) << c;
    endfunction

    assign Din_ready  = En & ~Mode;
    assign xfer_s     = Din_valid & Din_ready;
    assign in_range_s = ({1'b0, Din} < LIMIT);

    // Next-state and next-output decode; priority is En, then Mode, then handshake.
    always_comb begin
        state_s = state_r;
        hot_s   = hot_r;
        code_s  = code_r;
        cnt_s   = cnt_r;
        err_s   = 1'b0;
        wrap_s  = 1'b0;
        if (!En) begin
            // Disabled: outputs off, Code keeps the last active index.
            state_s = IDLE;
            hot_s   = '0;
            cnt_s   = '0;
        end else if (Mode) begin
            if (state_r != SCAN) begin
                // Fresh scan always starts at line 0.
                state_s = SCAN;
                code_s  = '0;
                hot_s   = onehot('0);
                cnt_s   = '0;
            end else if (cnt_r == DWELL_LAST) begin
                cnt_s = '0;
                if (code_r == LAST_CODE) begin
                    code_s = '0;
                    wrap_s = 1'b1;
                end else begin
                    code_s = code_r + SEL_W'(1);
                end
                hot_s = onehot(code_s);
            end else begin
                cnt_s = cnt_r + CNT_W'(1);
            end
        end else begin
            if (state_r == SCAN) begin
                // Leaving SCAN drops the output; a code taken this cycle still decodes.
                state_s = IDLE;
                hot_s   = '0;
                cnt_s   = '0;
            end else begin
                cnt_s = '0;
            end
            if (xfer_s && in_range_s) begin
                state_s = HOLD;
                code_s  = Din;
                hot_s   = onehot(Din);
            end else if (xfer_s) begin
                // Out-of-range code: flag it, but never as a two-cycle pulse.
                err_s = ~err_r;
            end else begin
                err_s = 1'b0;
            end
        end
    end

    // State and output registers with synchronous reset dominating all inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            hot_r   <= '0;
            code_r  <= '0;
            cnt_r   <= '0;
            err_r   <= 1'b0;
            wrap_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            hot_r   <= hot_s;
            code_r  <= code_s;
            cnt_r   <= cnt_s;
            err_r   <= err_s;
            wrap_r  <= wrap_s;
        end
    end

    assign Do   = hot_r ^ {NUM_OUT{ACTIVE_LOW}};
    assign Code = code_r;
    assign Err  = err_r;
    assign Wrap = wrap_r;

endmodule
